// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel-write / frame-request / status bundle between the SoC glue and one
// WS2812 chain sequencer.
interface ws2812_frame_ctrl_if #(
    parameter int ADDR_W = 1
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              start;
    logic              led_d;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  led_d, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output led_d, busy, done
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 chain sequencer: GRB pixel buffer, NRZ bit serialiser and latch gap,
// all state in the 16 MHz hfclk domain.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS  = 2,
    parameter int ADDR_W    = 1,
    parameter int T0H       = 6,
    parameter int T1H       = 13,
    parameter int TBIT      = 20,
    parameter int RESET_CYC = 1280
) (
    input logic               clk,
    input logic               reset,
    ws2812_frame_ctrl_if.slave bus
);

    localparam int CNT_W = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int BIT_W = 5;
    localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
    localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [BIT_W-1:0]  bit_r, bit_s;
    logic [PIX_W-1:0]  pix_idx_r, pix_idx_s;
    logic [LAT_W-1:0]  lat_r, lat_s;
    logic [23:0]       shift_r, shift_s;
    logic              led_r, led_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [23:0]       pix_r [NUM_LEDS];

    logic [PIX_W-1:0]  pix_inc_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [CNT_W-1:0]  th_s;

    assign pix_inc_s = pix_idx_r + PIX_W'(1'b1);
    assign cnt_inc_s = cnt_r + CNT_W'(1'b1);
    assign th_s      = shift_r[23] ? CNT_W'(T1H) : CNT_W'(T0H);

    assign bus.led_d = led_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

    // Pixel buffer: writable in any state; addresses past the chain are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pix_r[i] <= 24'h000000;
            end
        end else if (bus.wr_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (bus.wr_addr == ADDR_W'(i)) begin
                    pix_r[i] <= bus.wr_data;
                end
            end
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_r     <= '0;
            pix_idx_r <= '0;
            lat_r     <= '0;
            shift_r   <= 24'h000000;
            led_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_r     <= bit_s;
            pix_idx_r <= pix_idx_s;
            lat_r     <= lat_s;
            shift_r   <= shift_s;
            led_r     <= led_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Next-state decode; led_s is the level for the coming cycle, so the
    // line itself only ever toggles from led_r.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_s     = bit_r;
        pix_idx_s = pix_idx_r;
        lat_s     = lat_r;
        shift_s   = shift_r;
        led_s     = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s     = '0;
                bit_s     = '0;
                pix_idx_s = '0;
                lat_s     = '0;
                if (bus.start) begin
                    state_s = ST_SEND;
                    shift_s = pix_r[0];
                    busy_s  = 1'b1;
                    led_s   = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_SEND: begin
                if (cnt_r == CNT_W'(TBIT - 1)) begin
                    cnt_s = '0;
                    if (bit_r == 5'd23) begin
                        bit_s = '0;
                        if (pix_idx_r == PIX_W'(NUM_LEDS - 1)) begin
                            state_s = ST_LATCH;
                            lat_s   = '0;
                        end else begin
                            pix_idx_s = pix_inc_s;
                            shift_s   = pix_r[pix_inc_s];
                            led_s     = 1'b1;
                        end
                    end else begin
                        bit_s   = bit_r + 5'd1;
                        shift_s = {shift_r[22:0], 1'b0};
                        led_s   = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                    led_s = (cnt_inc_s < th_s);
                end
            end
            ST_LATCH: begin
                if (lat_r == LAT_W'(RESET_CYC - 1)) begin
                    state_s   = ST_IDLE;
                    lat_s     = '0;
                    cnt_s     = '0;
                    bit_s     = '0;
                    pix_idx_s = '0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                end else begin
                    lat_s = lat_r + LAT_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Scoreboard bench: expected pulse widths / low gaps / busy lengths are queued
// as stimulus is issued; a negedge monitor pops them as the line produces them.
module tb_ws2812_frame_ctrl;

    localparam int T0H       = 6;
    localparam int T1H       = 13;
    localparam int TBIT      = 20;
    localparam int RESET_CYC = 1280;

    typedef struct {
        int kind;   // 0 = led_d pulse, 1 = done pulse
        int high;   // pulse width, or busy length for done
        int low;    // low cycles before the pulse, -1 = don't care
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   sel   = 1'b0;

    ws2812_frame_ctrl_if #(.ADDR_W(1)) if0 ();
    ws2812_frame_ctrl_if #(.ADDR_W(1)) if1 ();

    ws2812_frame_ctrl dut0 (.clk(clk), .reset(reset), .bus(if0));
    ws2812_frame_ctrl #(.NUM_LEDS(1), .ADDR_W(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic check_obs(input int kind, input int high, input int low);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_%s: got len=%0d low=%0d, required no output",
                     (kind == 1) ? "done" : "pulse", high, low);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.high != high || (e.low >= 0 && e.low != low)) begin
                n_miss++;
                $display("FAIL %s: got kind=%0d len=%0d low=%0d, required kind=%0d len=%0d low=%0d",
                         (e.kind == 1) ? "done_busy_len" : "pulse", kind, high, low,
                         e.kind, e.high, e.low);
            end
        end
    endtask

    task automatic chk(input string name, input int actual, input int required);
        n_vec++;
        if (actual != required) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1, input int npix,
                              input int nbits, input int first_low, input bit with_done);
        exp_t        e;
        logic [23:0] px;
        int          prev_h = -1;
        int          cnt = 0;
        for (int j = 0; j < npix; j++) begin
            px = (j == 0) ? p0 : p1;
            for (int b = 23; b >= 0; b--) begin
                if (cnt < nbits) begin
                    e.kind = 0;
                    e.high = px[b] ? T1H : T0H;
                    e.low  = (prev_h < 0) ? first_low : (TBIT - prev_h);
                    sb_q.push_back(e);
                    prev_h = e.high;
                    cnt++;
                end
            end
        end
        if (with_done) begin
            e.kind = 1;
            e.high = npix * 24 * TBIT + RESET_CYC;
            e.low  = -1;
            sb_q.push_back(e);
        end
    endtask

    // Monitor on the selected chain, sampled on the falling edge.
    initial begin
        int  hi_cnt = 0, lo_cnt = 0, lo_before = -1, busy_run = 0;
        bit  lo_known = 0, was_hi = 0, prev_busy = 0;
        logic led, bsy, dn;
        forever begin
            @(negedge clk);
            if (reset) begin
                hi_cnt = 0; lo_cnt = 0; lo_known = 0; was_hi = 0;
                busy_run = 0; prev_busy = 0;
            end else begin
                led = sel ? if1.led_d : if0.led_d;
                bsy = sel ? if1.busy  : if0.busy;
                dn  = sel ? if1.done  : if0.done;
                if (led) begin
                    if (!was_hi) begin
                        lo_before = lo_known ? lo_cnt : -1;
                        hi_cnt = 0;
                    end
                    hi_cnt++;
                end else begin
                    if (was_hi) begin
                        check_obs(0, hi_cnt, lo_before);
                        lo_cnt = 0;
                        lo_known = 1;
                    end
                    lo_cnt++;
                end
                was_hi = led;
                if (dn) check_obs(1, prev_busy ? busy_run : -2, -1);
                if (bsy) busy_run = prev_busy ? busy_run + 1 : 1;
                prev_busy = bsy;
            end
        end
    end

    task automatic wr(input logic [0:0] addr, input logic [23:0] data);
        @(negedge clk);
        if (sel) begin if1.wr_en = 1'b1; if1.wr_addr = addr; if1.wr_data = data; end
        else     begin if0.wr_en = 1'b1; if0.wr_addr = addr; if0.wr_data = data; end
        @(negedge clk);
        if0.wr_en = 1'b0;
        if1.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel) if1.start = 1'b1; else if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int  t = 0;
        logic bsy;
        bsy = 1'b1;
        while ((sb_q.size() != 0 || bsy) && t < 6000) begin
            @(negedge clk);
            #1;
            bsy = sel ? if1.busy : if0.busy;
            t++;
        end
        if (t >= 6000) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got %0d outstanding expectations, required 0", name, sb_q.size());
            sb_q.delete();
        end
        wait_cycles(3);
    endtask

    task automatic start_in_done_cycle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!if0.done && t < 6000);
        chk("done_seen_for_b2b", int'(if0.done), 1);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    initial begin
        if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = 24'h0; if0.start = 1'b0;
        if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_data = 24'h0; if1.start = 1'b0;

        // reset state
        #12;
        chk("rst_led_d", int'(if0.led_d), 0);
        chk("rst_busy",  int'(if0.busy),  0);
        chk("rst_done",  int'(if0.done),  0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);

        // basic frame: 8x13, 39x6, 1x13, busy 2240, done right after
        wr(1'b0, 24'hFF0000);
        wr(1'b1, 24'h000001);
        push_frame(24'hFF0000, 24'h000001, 2, 48, -1, 1'b1);
        pulse_start();
        wait_idle("frame_basic");

        // start mid-frame is ignored
        push_frame(24'hFF0000, 24'h000001, 2, 48, -1, 1'b1);
        pulse_start();
        wait_cycles(498);
        chk("busy_midframe", int'(if0.busy), 1);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        wait_idle("frame_ignored_start");

        // rewrite of pixel 1 during pixel 0 bit 10 reaches this frame
        push_frame(24'hFF0000, 24'h00FF00, 2, 48, -1, 1'b1);
        pulse_start();
        wait_cycles(205);
        wr(1'b1, 24'h00FF00);
        wait_idle("frame_live_write");

        // reset during bit 14: only bits 0..13 complete
        push_frame(24'hFF0000, 24'h00FF00, 2, 14, -1, 1'b0);
        pulse_start();
        wait_cycles(284);
        chk("led_before_reset", int'(if0.led_d), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_led_d", int'(if0.led_d), 0);
        chk("async_rst_busy",  int'(if0.busy),  0);
        chk("async_rst_done",  int'(if0.done),  0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        chk("partial_frame_drained", sb_q.size(), 0);
        sb_q.delete();

        // cleared buffer sends zeros; second frame started in the done cycle
        push_frame(24'h000000, 24'h000000, 2, 48, -1, 1'b1);
        push_frame(24'h000000, 24'h000000, 2, 48, (TBIT - T0H) + RESET_CYC + 1, 1'b1);
        pulse_start();
        start_in_done_cycle();
        wait_idle("frame_b2b");

        // single-LED chain: address 1 write ignored, 24 bits only
        sel = 1'b1;
        wait_cycles(2);
        wr(1'b0, 24'hA50001);
        wr(1'b1, 24'hFFFFFF);
        push_frame(24'hA50001, 24'h000000, 1, 24, -1, 1'b1);
        pulse_start();
        wait_idle("frame_one_led");

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
